instruction_fetch: RTL and testbench

Fetch stage of the core pipeline. Owns the program counter and issues word reads on the instruction memory port using a request/acknowledge handshake. Presents one 32-bit instruction per beat, with an isNOP bubble flag, to the instruction decode stage that sits directly downstream. Accepts PC redirects from execute/trap logic and reports fetch faults.

---
 rtl/instruction_fetch.sv | 257 +++++++++++++++++++++++++
 tb/tb_instruction_fetch.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage of the core pipeline.
//
// Owns the program counter and reads instruction words over a request/acknowledge memory
// port. One instruction is presented per beat to decode together with an isNOP bubble flag.
// PC redirects from execute/trap logic are accepted in any state. Misaligned redirect targets
// and bus errors are reported on sticky flags.
//
// Optional feature: define FETCH_PREFETCH_EN to add a one-entry prefetch buffer. With it, the
// stage sustains one instruction per cycle with zero-wait memory. Without it, each instruction
// costs one FETCH beat and one ISSUED beat.
//
// Ports:
//   clk                 core clock, rising edge
//   rst                 asynchronous active-high reset
//   pipeStall           decode is not consuming; hold the presented instruction
//   jumpEnable          single-cycle redirect strobe
//   jumpAddress         redirect target
//   fetchRequest        memory read request, held until fetchAck
//   fetchAddress        word-aligned read address, held until fetchAck
//   fetchData           read data, valid with fetchAck
//   fetchAck            single-cycle read completion
//   fetchError          bus error, qualified by fetchAck
//   currentInstruction  instruction to decode (NOP_INSTRUCTION while isNOP)
//   currentPC           address of currentInstruction
//   isNOP               no valid instruction presented
//   fetchMisaligned     sticky: last redirect target was not word aligned
//   fetchBusError       sticky: bus error on a fetch

module instruction_fetch #(
    parameter logic [31:0] RESET_VECTOR    = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTRUCTION = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipeStall,
    input  logic        jumpEnable,
    input  logic [31:0] jumpAddress,
    output logic        fetchRequest,
    output logic [31:0] fetchAddress,
    input  logic [31:0] fetchData,
    input  logic        fetchAck,
    input  logic        fetchError,
    output logic [31:0] currentInstruction,
    output logic [31:0] currentPC,
    output logic        isNOP,
    output logic        fetchMisaligned,
    output logic        fetchBusError
);

    typedef enum logic [1:0] {StStart, StFetch, StIssued, StFault} fetchStateT;

    fetchStateT  stateQ, stateD;
    logic [31:0] pcQ, pcD;
    logic [29:0] addrQ, addrD;     // word address on the bus, decoupled from pc
    logic [31:0] instrQ, instrD;
    logic [31:0] curPcQ, curPcD;
    logic        isNopQ, isNopD;
    logic        misalignQ, misalignD;
    logic        busErrQ, busErrD;
    logic        pendingQ, pendingD; // redirect seen while a read was in flight

    logic [31:0] nextPc;
    logic        jumpAligned;
    logic        outstanding;

`ifdef FETCH_PREFETCH_EN
    logic [31:0] bufDataQ, bufDataD;
    logic [31:0] bufPcQ, bufPcD;
    logic        bufValidQ, bufValidD;
    logic        bufErrQ, bufErrD;
    logic        hitErr;
    logic [31:0] hitData;
    logic [31:0] hitPc;
`endif

    assign nextPc      = pcQ + 32'd4;
    assign jumpAligned = (jumpAddress[1:0] == 2'b00);

`ifdef FETCH_PREFETCH_EN
    // While ISSUED, the next word is requested until it lands in the buffer.
    assign outstanding = (stateQ == StFetch) || ((stateQ == StIssued) && !bufValidQ);
`else
    assign outstanding = (stateQ == StFetch);
`endif

    assign fetchRequest       = outstanding;
    assign fetchAddress       = {addrQ, 2'b00};
    assign currentInstruction = isNopQ ? NOP_INSTRUCTION : instrQ;
    assign currentPC          = curPcQ;
    assign isNOP              = isNopQ;
    assign fetchMisaligned    = misalignQ;
    assign fetchBusError      = busErrQ;

    always_comb begin
        stateD    = stateQ;
        pcD       = pcQ;
        addrD     = addrQ;
        instrD    = instrQ;
        curPcD    = curPcQ;
        isNopD    = isNopQ;
        misalignD = misalignQ;
        busErrD   = busErrQ;
        pendingD  = pendingQ;
`ifdef FETCH_PREFETCH_EN
        bufDataD  = bufDataQ;
        bufPcD    = bufPcQ;
        bufValidD = bufValidQ;
        bufErrD   = bufErrQ;
        hitErr    = bufValidQ ? bufErrQ : fetchError;
        hitData   = bufValidQ ? bufDataQ : fetchData;
        hitPc     = bufValidQ ? bufPcQ : nextPc;
`endif

        unique case (stateQ)
            StStart: begin
                stateD = StFetch;
            end

            StFetch: begin
                isNopD = 1'b1;
                if (fetchAck) begin
                    pendingD = 1'b0;
                    // Re-aim the bus at pc; after a discarded read this is the redirect target.
                    addrD    = pcQ[31:2];
                    // A read squashed by a redirect is dropped, including any error it carried.
                    if (!pendingQ) begin
                        if (fetchError) begin
                            busErrD = 1'b1;
                            stateD  = StFault;
                        end else begin
                            instrD = fetchData;
                            curPcD = pcQ;
                            isNopD = 1'b0;
                            stateD = StIssued;
`ifdef FETCH_PREFETCH_EN
                            addrD  = nextPc[31:2];
`endif
                        end
                    end
                end
            end

            StIssued: begin
`ifdef FETCH_PREFETCH_EN
                if (fetchAck && !bufValidQ) begin
                    bufValidD = 1'b1;
                    bufDataD  = fetchData;
                    bufErrD   = fetchError;
                    bufPcD    = nextPc;
                end
                if (!pipeStall) begin
                    pcD = nextPc;
                    if (bufValidQ || fetchAck) begin
                        bufValidD = 1'b0;
                        if (hitErr) begin
                            // Prefetch error surfaces only when that entry would be presented.
                            busErrD = 1'b1;
                            isNopD  = 1'b1;
                            stateD  = StFault;
                        end else begin
                            instrD = hitData;
                            curPcD = hitPc;
                            isNopD = 1'b0;
                            addrD  = nextPc[31:2] + 30'd1;
                        end
                    end else begin
                        // Read of pc+4 is already on the bus; FETCH simply waits for it.
                        isNopD = 1'b1;
                        stateD = StFetch;
                    end
                end
`else
                if (!pipeStall) begin
                    pcD    = nextPc;
                    addrD  = nextPc[31:2];
                    isNopD = 1'b1;
                    stateD = StFetch;
                end
`endif
            end

            StFault: begin
                isNopD = 1'b1;
            end

            default: begin
                stateD = StStart;
            end
        endcase

        // Redirects override whatever the state logic decided.
        if (jumpEnable) begin
            isNopD = 1'b1;
`ifdef FETCH_PREFETCH_EN
            bufValidD = 1'b0;
`endif
            if (!jumpAligned) begin
                misalignD = 1'b1;
                pendingD  = 1'b0;
                stateD    = StFault;
            end else begin
                pcD       = jumpAddress;
                misalignD = 1'b0;
                busErrD   = 1'b0;
                stateD    = StFetch;
                if (outstanding && !fetchAck) begin
                    // Keep the in-flight read stable; its data is thrown away on the ack.
                    pendingD = 1'b1;
                end else begin
                    pendingD = 1'b0;
                    addrD    = jumpAddress[31:2];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ    <= StStart;
            pcQ       <= RESET_VECTOR;
            addrQ     <= RESET_VECTOR[31:2];
            instrQ    <= NOP_INSTRUCTION;
            curPcQ    <= RESET_VECTOR;
            isNopQ    <= 1'b1;
            misalignQ <= 1'b0;
            busErrQ   <= 1'b0;
            pendingQ  <= 1'b0;
        end else begin
            stateQ    <= stateD;
            pcQ       <= pcD;
            addrQ     <= addrD;
            instrQ    <= instrD;
            curPcQ    <= curPcD;
            isNopQ    <= isNopD;
            misalignQ <= misalignD;
            busErrQ   <= busErrD;
            pendingQ  <= pendingD;
        end
    end

`ifdef FETCH_PREFETCH_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bufDataQ  <= NOP_INSTRUCTION;
            bufPcQ    <= RESET_VECTOR;
            bufValidQ <= 1'b0;
            bufErrQ   <= 1'b0;
        end else begin
            bufDataQ  <= bufDataD;
            bufPcQ    <= bufPcD;
            bufValidQ <= bufValidD;
            bufErrQ   <= bufErrD;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch (default build).
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipeStall;
    logic        jumpEnable;
    logic [31:0] jumpAddress;
    logic        fetchRequest;
    logic [31:0] fetchAddress;
    logic [31:0] fetchData;
    logic        fetchAck;
    logic        fetchError;
    logic [31:0] currentInstruction;
    logic [31:0] currentPC;
    logic        isNOP;
    logic        fetchMisaligned;
    logic        fetchBusError;

    // Memory model: autoAck answers every request in the same cycle (zero-wait).
    logic        autoAck;
    logic        ackManual;
    logic [31:0] dataManual;
    logic        errEn;
    logic [31:0] errAddr;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h0000_0093;
        if (a == 32'h0000_0004) return 32'h0010_0113;
        return a ^ 32'hA5A5_0000;
    endfunction

    assign fetchAck   = autoAck ? fetchRequest : ackManual;
    assign fetchData  = autoAck ? memWord(fetchAddress) : dataManual;
    assign fetchError = fetchAck && errEn && (fetchAddress == errAddr);

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk                (clk),
        .rst                (rst),
        .pipeStall          (pipeStall),
        .jumpEnable         (jumpEnable),
        .jumpAddress        (jumpAddress),
        .fetchRequest       (fetchRequest),
        .fetchAddress       (fetchAddress),
        .fetchData          (fetchData),
        .fetchAck           (fetchAck),
        .fetchError         (fetchError),
        .currentInstruction (currentInstruction),
        .currentPC          (currentPC),
        .isNOP              (isNOP),
        .fetchMisaligned    (fetchMisaligned),
        .fetchBusError      (fetchBusError)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; pipeStall = 1'b0; jumpEnable = 1'b0; jumpAddress = '0;
        autoAck = 1'b1; ackManual = 1'b0; dataManual = '0; errEn = 1'b0; errAddr = '0;
        cyc(); cyc();
        check("rst_req",   {31'd0, fetchRequest}, 32'd0);
        check("rst_addr",  fetchAddress, 32'h0);
        check("rst_isnop", {31'd0, isNOP}, 32'd1);
        check("rst_instr", currentInstruction, NOP);
        check("rst_pc",    currentPC, 32'h0);
        check("rst_mis",   {31'd0, fetchMisaligned}, 32'd0);
        check("rst_berr",  {31'd0, fetchBusError}, 32'd0);
        rst = 1'b0;

        // Zero-wait sequential fetch of 0 and 4.
        cyc();
        check("f0_req",   {31'd0, fetchRequest}, 32'd1);
        check("f0_addr",  fetchAddress, 32'h0);
        check("f0_isnop", {31'd0, isNOP}, 32'd1);
        cyc();
        check("i0_isnop", {31'd0, isNOP}, 32'd0);
        check("i0_instr", currentInstruction, 32'h0000_0093);
        check("i0_pc",    currentPC, 32'h0);
        check("i0_req",   {31'd0, fetchRequest}, 32'd0);
        cyc();
        check("f4_isnop", {31'd0, isNOP}, 32'd1);
        check("f4_addr",  fetchAddress, 32'h4);
        pipeStall = 1'b1;
        cyc();
        check("i4_isnop", {31'd0, isNOP}, 32'd0);
        check("i4_instr", currentInstruction, 32'h0010_0113);
        check("i4_pc",    currentPC, 32'h4);

        // Stall holds the presented instruction.
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("stall_instr", currentInstruction, 32'h0010_0113);
            check("stall_pc",    currentPC, 32'h4);
            check("stall_req",   {31'd0, fetchRequest}, 32'd0);
        end
        pipeStall = 1'b0;
        autoAck = 1'b0;
        cyc();
        check("f8_req",  {31'd0, fetchRequest}, 32'd1);
        check("f8_addr", fetchAddress, 32'h8);

        // Redirect while the read of 8 is outstanding.
        jumpEnable = 1'b1; jumpAddress = 32'h0000_0100;
        cyc();
        jumpEnable = 1'b0;
        check("pend_addr",  fetchAddress, 32'h8);
        check("pend_req",   {31'd0, fetchRequest}, 32'd1);
        check("pend_isnop", {31'd0, isNOP}, 32'd1);
        cyc();
        check("pend_addr2", fetchAddress, 32'h8);
        dataManual = memWord(32'h8); ackManual = 1'b1;
        cyc();
        ackManual = 1'b0;
        check("disc_isnop", {31'd0, isNOP}, 32'd1);
        check("disc_instr", currentInstruction, NOP);
        check("disc_addr",  fetchAddress, 32'h100);
        check("disc_req",   {31'd0, fetchRequest}, 32'd1);
        autoAck = 1'b1;
        cyc();
        check("j100_instr", currentInstruction, 32'hA5A5_0100);
        check("j100_pc",    currentPC, 32'h100);

        // Misaligned redirect, then recovery.
        jumpEnable = 1'b1; jumpAddress = 32'h0000_0102;
        cyc();
        jumpEnable = 1'b0;
        check("mis_flag",  {31'd0, fetchMisaligned}, 32'd1);
        check("mis_req",   {31'd0, fetchRequest}, 32'd0);
        check("mis_isnop", {31'd0, isNOP}, 32'd1);
        cyc();
        check("mis_sticky", {31'd0, fetchMisaligned}, 32'd1);
        check("mis_req2",   {31'd0, fetchRequest}, 32'd0);
        jumpEnable = 1'b1; jumpAddress = 32'h0000_0200;
        cyc();
        jumpEnable = 1'b0;
        check("rec_mis",  {31'd0, fetchMisaligned}, 32'd0);
        check("rec_req",  {31'd0, fetchRequest}, 32'd1);
        check("rec_addr", fetchAddress, 32'h200);
        cyc();
        check("j200_instr", currentInstruction, 32'hA5A5_0200);
        check("j200_pc",    currentPC, 32'h200);

        // Bus error at 0x10.
        errEn = 1'b1; errAddr = 32'h10;
        jumpEnable = 1'b1; jumpAddress = 32'h0000_0010;
        cyc();
        jumpEnable = 1'b0;
        check("be_addr", fetchAddress, 32'h10);
        check("be_req",  {31'd0, fetchRequest}, 32'd1);
        cyc();
        check("be_flag",  {31'd0, fetchBusError}, 32'd1);
        check("be_isnop", {31'd0, isNOP}, 32'd1);
        check("be_req0",  {31'd0, fetchRequest}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            check("be_noreq", {31'd0, fetchRequest}, 32'd0);
        end
        errEn = 1'b0;

        // PC wrap at the top of the address space.
        jumpEnable = 1'b1; jumpAddress = 32'hFFFF_FFFC;
        cyc();
        jumpEnable = 1'b0;
        check("wr_berr", {31'd0, fetchBusError}, 32'd0);
        check("wr_addr", fetchAddress, 32'hFFFF_FFFC);
        cyc();
        check("wr_pc",    currentPC, 32'hFFFF_FFFC);
        check("wr_instr", currentInstruction, 32'h5A5A_FFFC);
        cyc();
        check("wr_next",  fetchAddress, 32'h0);
        check("wr_nreq",  {31'd0, fetchRequest}, 32'd1);
        check("wr_nop",   currentInstruction, NOP);
        cyc();
        check("wr0_pc",    currentPC, 32'h0);
        check("wr0_instr", currentInstruction, 32'h0000_0093);

        // Redirect coinciding with an ack: data dropped, target requested next.
        cyc();
        check("co_addr4", fetchAddress, 32'h4);
        jumpEnable = 1'b1; jumpAddress = 32'h0000_0300;
        cyc();
        jumpEnable = 1'b0;
        check("co_addr",  fetchAddress, 32'h300);
        check("co_isnop", {31'd0, isNOP}, 32'd1);
        check("co_req",   {31'd0, fetchRequest}, 32'd1);
        cyc();
        check("co_instr", currentInstruction, 32'hA5A5_0300);
        check("co_pc",    currentPC, 32'h300);

        // Reset mid-transaction drops the request at once; a late ack is ignored.
        autoAck = 1'b0;
        cyc();
        check("mr_req1", {31'd0, fetchRequest}, 32'd1);
        check("mr_addr", fetchAddress, 32'h304);
        #2 rst = 1'b1;
        #1;
        check("mr_req0",  {31'd0, fetchRequest}, 32'd0);
        check("mr_addr0", fetchAddress, 32'h0);
        cyc();
        rst = 1'b0; ackManual = 1'b1; dataManual = 32'hDEAD_BEEF;
        cyc();
        ackManual = 1'b0;
        check("mr_isnop", {31'd0, isNOP}, 32'd1);
        check("mr_instr", currentInstruction, NOP);
        check("mr_freq",  {31'd0, fetchRequest}, 32'd1);
        check("mr_faddr", fetchAddress, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
